// File: rtl/ptw_sv39_pkg.sv
// Shared types and constants for the Sv39 page-table walker.
package ptw_sv39_pkg;

    localparam int unsigned PAGE_SHIFT = 12;
    localparam int unsigned PTE_SHIFT  = 3;
    localparam logic [3:0]  SV39_MODE  = 4'd8;
    localparam int unsigned VPN_BITS   = 9;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StResp,
        StDrain
    } ptw_state_e;

    typedef struct packed {
        logic        id;
        logic [63:0] pte;
        logic [1:0]  level;
        logic        fault;
    } ptw_resp_t;

endpackage

// File: rtl/ptw_sv39_pte_decode.sv
// Field extraction and structural checks for one Sv39 PTE at a given walk level.
module ptw_sv39_pte_decode (
    input  logic [63:0] pte,
    input  logic [1:0]  level,
    output logic [43:0] ppn,
    output logic        leaf,
    output logic        invalid,
    output logic        misaligned,
    output logic        a_bit
);

    logic unused_pte;

    assign ppn        = pte[53:10];
    assign leaf       = pte[1] | pte[3];
    // Write-only encodings are reserved.
    assign invalid    = ~pte[0] | (~pte[1] & pte[2]);
    assign a_bit      = pte[6];
    assign unused_pte = ^{pte[63:54], pte[9:7], pte[5:4]};

    always_comb begin
        case (level)
            2'd2:    misaligned = |ppn[17:0];
            2'd1:    misaligned = |ppn[8:0];
            default: misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/ptw_sv39.sv
// Sv39 page-table walker with round-robin I-TLB/D-TLB arbitration.
// Optional PTW_AD_CHECK_EN: leaves with A = 0 are reported as page faults.
module ptw_sv39
    import ptw_sv39_pkg::*;
#(
    parameter int unsigned LEVELS   = 3,
    parameter int unsigned PA_WIDTH = 56
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [63:0]         satp,
    input  logic                flush,
    input  logic                itlb_req_valid,
    output logic                itlb_req_ready,
    input  logic [26:0]         itlb_req_vpn,
    input  logic                dtlb_req_valid,
    output logic                dtlb_req_ready,
    input  logic [26:0]         dtlb_req_vpn,
    output logic                resp_valid,
    output logic                resp_id,
    output logic [63:0]         resp_pte,
    output logic [1:0]          resp_level,
    output logic                resp_fault,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [PA_WIDTH-1:0] mem_addr,
    input  logic                mem_resp_valid,
    input  logic [63:0]         mem_rdata
);

    localparam logic [1:0] TOP_LEVEL = 2'(LEVELS - 1);

    ptw_state_e  state_q, state_d;
    logic [43:0] cur_ppn_q, cur_ppn_d;
    logic [26:0] vpn_q, vpn_d;
    logic [1:0]  level_q, level_d;
    logic        rr_last_q, rr_last_d;
    ptw_resp_t   resp_q, resp_d;

    logic [43:0] pte_ppn;
    logic        pte_leaf, pte_invalid, pte_misaligned, pte_a;
    logic        ad_fault, pte_fault;
    logic        grant_i, grant_d;
    logic [8:0]  vpn_sel;
    logic        unused_satp;

    assign unused_satp = ^satp[59:44];

    ptw_sv39_pte_decode u_pte_decode (
        .pte        (mem_rdata),
        .level      (level_q),
        .ppn        (pte_ppn),
        .leaf       (pte_leaf),
        .invalid    (pte_invalid),
        .misaligned (pte_misaligned),
        .a_bit      (pte_a)
    );

`ifdef PTW_AD_CHECK_EN
    assign ad_fault = ~pte_a;
`else
    logic unused_a;
    assign unused_a = pte_a;
    assign ad_fault = 1'b0;
`endif

    assign pte_fault = pte_invalid | (pte_leaf & (pte_misaligned | ad_fault)) |
                       (~pte_leaf & (level_q == 2'd0));

    // rr_last_q = 1 means the D-TLB was granted last, so the I-TLB wins a tie.
    assign grant_i = itlb_req_valid & (~dtlb_req_valid | rr_last_q);
    assign grant_d = dtlb_req_valid & (~itlb_req_valid | ~rr_last_q);

    always_comb begin
        case (level_q)
            2'd2:    vpn_sel = vpn_q[26:18];
            2'd1:    vpn_sel = vpn_q[17:9];
            default: vpn_sel = vpn_q[8:0];
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cur_ppn_d      = cur_ppn_q;
        vpn_d          = vpn_q;
        level_d        = level_q;
        rr_last_d      = rr_last_q;
        resp_d         = resp_q;
        itlb_req_ready = 1'b0;
        dtlb_req_ready = 1'b0;
        mem_req_valid  = 1'b0;
        mem_addr       = '0;
        resp_valid     = 1'b0;
        resp_id        = 1'b0;
        resp_pte       = '0;
        resp_level     = '0;
        resp_fault     = 1'b0;

        unique case (state_q)
            StIdle: begin
                itlb_req_ready = grant_i & ~flush;
                dtlb_req_ready = grant_d & ~flush;
                if ((itlb_req_valid & itlb_req_ready) | (dtlb_req_valid & dtlb_req_ready)) begin
                    vpn_d      = dtlb_req_ready ? dtlb_req_vpn : itlb_req_vpn;
                    rr_last_d  = dtlb_req_ready;
                    cur_ppn_d  = satp[43:0];
                    level_d    = TOP_LEVEL;
                    resp_d.id  = dtlb_req_ready;
                    resp_d.pte = '0;
                    resp_d.level = TOP_LEVEL;
                    if (satp[63:60] != SV39_MODE) begin
                        resp_d.fault = 1'b1;
                        state_d      = StResp;
                    end else begin
                        resp_d.fault = 1'b0;
                        state_d      = StReq;
                    end
                end
            end
            StReq: begin
                mem_req_valid = 1'b1;
                mem_addr      = PA_WIDTH'({cur_ppn_q, {PAGE_SHIFT{1'b0}}}) +
                                PA_WIDTH'({vpn_sel, {PTE_SHIFT{1'b0}}});
                if (mem_req_ready) begin
                    state_d = flush ? StDrain : StWait;
                end else if (flush) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (mem_resp_valid) begin
                    if (flush) begin
                        state_d = StIdle;
                    end else if (pte_fault) begin
                        resp_d.fault = 1'b1;
                        resp_d.pte   = '0;
                        resp_d.level = level_q;
                        state_d      = StResp;
                    end else if (pte_leaf) begin
                        resp_d.pte   = mem_rdata;
                        resp_d.level = level_q;
                        state_d      = StResp;
                    end else begin
                        cur_ppn_d = pte_ppn;
                        level_d   = level_q - 2'd1;
                        state_d   = StReq;
                    end
                end else if (flush) begin
                    state_d = StDrain;
                end
            end
            StResp: begin
                resp_valid = 1'b1;
                resp_id    = resp_q.id;
                resp_pte   = resp_q.fault ? 64'd0 : resp_q.pte;
                resp_level = resp_q.level;
                resp_fault = resp_q.fault;
                state_d    = StIdle;
            end
            StDrain: begin
                if (mem_resp_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            cur_ppn_q <= '0;
            vpn_q     <= '0;
            level_q   <= TOP_LEVEL;
            rr_last_q <= 1'b1;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            cur_ppn_q <= cur_ppn_d;
            vpn_q     <= vpn_d;
            level_q   <= level_d;
            rr_last_q <= rr_last_d;
            resp_q    <= resp_d;
        end
    end

endmodule

// File: doc/ptw_sv39.md
Name: ptw_sv39

Overview:
- Sv39 hardware page-table walker with a built-in round-robin arbiter between the instruction-TLB and data-TLB miss ports.
- Accepts one VPN miss at a time and issues up to three 64-bit PTE reads to the memory port.
- Decodes each PTE and returns either the leaf PTE with its level, or a page-fault indication, to the requester that issued the miss.
- Sits between the TLBs and the D-cache/bus read port, next to the MMU.

Parameters:
- LEVELS, 3, number of page-table levels (Sv39).
- PA_WIDTH, 56, physical address width driven on mem_addr; upper bits are zero.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- satp  in  64  current satp; root PPN = satp[43:0]; mode = satp[63:60] (8 = Sv39).
- flush  in  1  sfence.vma; aborts any walk in progress.
- itlb_req_valid  in  1  I-TLB miss request.
- itlb_req_ready  out  1  I-TLB request accepted this cycle.
- itlb_req_vpn  in  27  I-TLB VPN[2:0].
- dtlb_req_valid  in  1  D-TLB miss request.
- dtlb_req_ready  out  1  D-TLB request accepted this cycle.
- dtlb_req_vpn  in  27  D-TLB VPN[2:0].
- resp_valid  out  1  one-cycle pulse: walk finished.
- resp_id  out  1  0 = I-TLB, 1 = D-TLB.
- resp_pte  out  64  raw leaf PTE; zero on fault.
- resp_level  out  2  level of the leaf (2 = 1 GiB, 1 = 2 MiB, 0 = 4 KiB).
- resp_fault  out  1  page fault.
- mem_req_valid  out  1  PTE read request.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  PA_WIDTH  PTE physical address.
- mem_resp_valid  in  1  read data valid.
- mem_rdata  in  64  PTE read data.

Behaviour:
- Reset (async, rstn low): state = IDLE, level = 2, rr_last = 1 (so I-TLB wins the first tie). All outputs 0: req_ready, resp_*, mem_req_valid, mem_addr.
- Sequencing:
  - States: IDLE, REQ, WAIT, RESP, DRAIN.
  - Internal: cur_ppn[43:0], vpn[26:0], id, level[1:0].
- IDLE: ready asserted only toward the arbiter winner.
  - Both requests valid: grant the port not granted last (round-robin). Otherwise grant whichever is valid.
  - Handshake = valid & ready in the same cycle. On handshake: latch vpn and id, cur_ppn = satp[43:0], level = 2, go to REQ.
  - flush high in IDLE: both readies forced 0.
- Bare mode: satp mode != 8 at handshake → go to RESP with fault = 1, no memory access.
- REQ:
  - mem_req_valid = 1; mem_addr = {cur_ppn, 12'b0} + {vpn[level], 3'b0}, truncated to PA_WIDTH.
  - mem_req_valid and mem_addr stay stable until mem_req_ready. Handshake → WAIT.
- WAIT: on mem_resp_valid, decode mem_rdata.
  - v = 0, or (r = 0 and w = 1) → fault.
  - Leaf (r | x): if level > 0 and ppn[9*level-1:0] != 0 → fault (misaligned superpage). Otherwise success; latch PTE and level.
  - Non-leaf and level = 0 → fault.
  - Non-leaf and level > 0 → cur_ppn = pte[53:10], level decrements, go to REQ.
- RESP:
  - resp_valid = 1 for exactly one cycle with id/pte/level/fault; resp_pte = 0 when fault.
  - Then → IDLE. The next grant is possible in the cycle after RESP.
- Latency: best case 1 (accept) + 3×(REQ+WAIT) + 1 (RESP) with zero-wait memory, i.e. 8 cycles for a 4 KiB page.
- Flush mid-walk:
  - In REQ before handshake: drop mem_req_valid, go to IDLE, no response.
  - In REQ on the handshake cycle, or in WAIT: go to DRAIN, consume and discard exactly one mem_resp_valid, then IDLE, no response.
  - In RESP: the response is still delivered.
- flush and a new request in the same cycle: flush wins and no grant is made.
- resp_valid is never asserted without a prior accepted request. There is at most one outstanding memory read.

Optional Feature:
- Macro: PTW_AD_CHECK_EN.
- Defined: a leaf with a = 0 returns fault = 1 (software-managed A/D bits).
- Undefined: the A/D bits are ignored, and the leaf is returned unchanged for the TLB/OS to handle.

Decomposition:
- PageStruct package gains:
  - PtwState enum {IDLE, REQ, WAIT, RESP, DRAIN}.
  - Constants PAGE_SHIFT = 12, PTE_SHIFT = 3, SV39_MODE = 4'd8, VPN_BITS = 9.
  - PtwResp struct {id, pte, level, fault}.
- Sub-module: instantiate the shared PTEDecode block on mem_rdata for field extraction. The arbiter and FSM stay inline.

Test Plan:
- Sv39, 4 KiB page:
  - Setup: satp = 8<<60 | 0x80000; I-TLB vpn = {2,1,3}; memory holds non-leaf PTEs → 0x80001, 0x80002; leaf 0x0000_0000_2000_00CF.
  - Response: three reads at 0x80000010, 0x80001008, 0x80002018; resp_id = 0, level = 0, fault = 0, pte matches, 8 cycles with zero-wait memory.
- 2 MiB superpage:
  - Leaf at level 1 with ppn[8:0] = 0 → level = 1, fault = 0, two reads.
  - Same leaf with ppn[8:0] = 1 → fault = 1, pte = 0.
- Invalid PTE:
  - Level-2 PTE = 0 → fault = 1 after one read.
  - PTE with r = 0, w = 1 → fault = 1.
- Arbitration:
  - I-TLB and D-TLB both valid for two consecutive walks → first grant I-TLB, second D-TLB. Readies are never both high.
- Flush in WAIT:
  - Assert flush while a read is outstanding; memory responds 3 cycles later → no resp_valid; the next request is accepted only after the drained response.
- Reset mid-walk:
  - rstn low during REQ → mem_req_valid drops asynchronously to 0, and state is IDLE after release.
- PTW_AD_CHECK_EN defined:
  - Leaf with a = 0 → fault = 1.
  - Same leaf with the macro undefined → fault = 0.
